// File: rtl/tm_stats_sched.sv
// tm_stats_sched: shares one pipelined transaction-statistics ALU among
// NUM_THREADS requesters. Each thread owns an (avg, inst) running-average
// pair. The block grants round-robin, issues {avg, inst, cur} to the ALU,
// tracks each op with a tag pipe, and writes the ALU result back to the
// owning thread. A thread with an op in flight cannot be granted again.
// Per-thread clear zeroes the stats and kills any in-flight result.
module tm_stats_sched #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2,
    parameter int ALU_LAT     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_THREADS-1:0]   req_valid,
    input  logic [8*NUM_THREADS-1:0] req_curlen,
    output logic [NUM_THREADS-1:0]   req_ready,
    input  logic                     clr_valid,
    input  logic [TID_W-1:0]         clr_tid,
    output logic [7:0]               alu_avg,
    output logic [7:0]               alu_inst,
    output logic [7:0]               alu_cur,
    input  logic [7:0]               alu_avg_new,
    input  logic [7:0]               alu_inst_new,
    output logic                     upd_valid,
    output logic [TID_W-1:0]         upd_tid,
    output logic [NUM_THREADS-1:0]   pending,
    input  logic [TID_W-1:0]         rd_tid,
    output logic [7:0]               rd_avg,
    output logic [7:0]               rd_inst
);

    localparam logic [TID_W:0] NT_L       = (TID_W+1)'(NUM_THREADS);
    localparam logic [7:0]     INST_MAX_L = 8'd255;

    // Reduce a (pointer + offset) sum back into the thread-id range.
    function automatic logic [TID_W-1:0] wrap_idx(input logic [TID_W:0] sum);
        logic [TID_W:0] r;
        r = (sum >= NT_L) ? (sum - NT_L) : sum;
        return r[TID_W-1:0];
    endfunction

    // The ALU divides by inst+1, so a saturated count is presented as 254.
    function automatic logic [7:0] issue_inst(input logic [7:0] v);
        return (v == INST_MAX_L) ? 8'd254 : v;
    endfunction

    logic [7:0]             avg_r  [NUM_THREADS];
    logic [7:0]             inst_r [NUM_THREADS];
    logic [NUM_THREADS-1:0] pending_r;
    logic [TID_W-1:0]       ptr_r;
    logic [ALU_LAT:0]       tag_vld_r;
    logic [TID_W-1:0]       tag_tid_r [ALU_LAT+1];
    logic [7:0]             alu_avg_r;
    logic [7:0]             alu_inst_r;
    logic [7:0]             alu_cur_r;
    logic                   upd_valid_r;
    logic [TID_W-1:0]       upd_tid_r;

    logic [NUM_THREADS-1:0] clr_hit_s;
    logic [NUM_THREADS-1:0] elig_s;
    logic [NUM_THREADS-1:0] req_ready_s;
    logic                   gnt_vld_s;
    logic [TID_W-1:0]       gnt_tid_s;
    logic [TID_W-1:0]       arb_cand_s;
    logic                   arb_take_s;
    logic [TID_W-1:0]       ptr_next_s;
    logic                   wb_s;
    logic [TID_W-1:0]       wb_tid_s;

    // Per-thread clear decode and grant eligibility (nothing eligible in reset).
    always_comb begin
        clr_hit_s = {NUM_THREADS{1'b0}};
        elig_s    = {NUM_THREADS{1'b0}};
        for (int i = 0; i < NUM_THREADS; i++) begin
            clr_hit_s[i] = clr_valid & (clr_tid == i[TID_W-1:0]);
            elig_s[i]    = ~reset & req_valid[i] & ~pending_r[i] & ~clr_hit_s[i];
        end
    end

    // Round-robin search starting at the pointer; first eligible thread wins.
    always_comb begin
        gnt_vld_s  = 1'b0;
        gnt_tid_s  = {TID_W{1'b0}};
        arb_cand_s = {TID_W{1'b0}};
        arb_take_s = 1'b0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            arb_cand_s = wrap_idx({1'b0, ptr_r} + k[TID_W:0]);
            arb_take_s = ~gnt_vld_s & elig_s[arb_cand_s];
            gnt_tid_s  = arb_take_s ? arb_cand_s : gnt_tid_s;
            gnt_vld_s  = gnt_vld_s | arb_take_s;
        end
        ptr_next_s = wrap_idx({1'b0, gnt_tid_s} + {{TID_W{1'b0}}, 1'b1});
    end

    // One-hot grant vector and the writeback qualified against a same-edge clear.
    always_comb begin
        req_ready_s = {NUM_THREADS{1'b0}};
        for (int i = 0; i < NUM_THREADS; i++) begin
            req_ready_s[i] = gnt_vld_s & (gnt_tid_s == i[TID_W-1:0]);
        end
        wb_tid_s = tag_tid_r[ALU_LAT];
        wb_s     = tag_vld_r[ALU_LAT] & ~(clr_valid & (clr_tid == wb_tid_s));
    end

    // Per-thread stats: clear beats writeback; a saturated count stays at 255.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (reset || clr_hit_s[i]) begin
                avg_r[i]  <= 8'd0;
                inst_r[i] <= 8'd0;
            end else if (wb_s && (wb_tid_s == i[TID_W-1:0])) begin
                avg_r[i]  <= alu_avg_new;
                inst_r[i] <= (inst_r[i] == INST_MAX_L) ? INST_MAX_L : alu_inst_new;
            end
        end
    end

    // In-flight flags: set on grant, dropped on writeback or clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {NUM_THREADS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (req_ready_s[i]) begin
                    pending_r[i] <= 1'b1;
                end else if (clr_hit_s[i] || (wb_s && (wb_tid_s == i[TID_W-1:0]))) begin
                    pending_r[i] <= 1'b0;
                end
            end
        end
    end

    // Tag pipe mirrors the ALU latency; a clear kills matching tags in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_r <= {(ALU_LAT+1){1'b0}};
            for (int k = 0; k <= ALU_LAT; k++) begin
                tag_tid_r[k] <= {TID_W{1'b0}};
            end
        end else begin
            tag_vld_r[0] <= gnt_vld_s;
            tag_tid_r[0] <= gnt_tid_s;
            for (int k = 1; k <= ALU_LAT; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1] & ~(clr_valid & (clr_tid == tag_tid_r[k-1]));
                tag_tid_r[k] <= tag_tid_r[k-1];
            end
        end
    end

    // ALU operand registers: loaded on a grant, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_avg_r  <= 8'd0;
            alu_inst_r <= 8'd0;
            alu_cur_r  <= 8'd0;
        end else if (gnt_vld_s) begin
            alu_avg_r  <= avg_r[gnt_tid_s];
            alu_inst_r <= issue_inst(inst_r[gnt_tid_s]);
            alu_cur_r  <= req_curlen[{gnt_tid_s, 3'b000} +: 8];
        end
    end

    // Writeback notification and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_r <= 1'b0;
            upd_tid_r   <= {TID_W{1'b0}};
            ptr_r       <= {TID_W{1'b0}};
        end else begin
            upd_valid_r <= wb_s;
            if (wb_s) begin
                upd_tid_r <= wb_tid_s;
            end
            if (gnt_vld_s) begin
                ptr_r <= ptr_next_s;
            end
        end
    end

    assign req_ready = req_ready_s;
    assign alu_avg   = alu_avg_r;
    assign alu_inst  = alu_inst_r;
    assign alu_cur   = alu_cur_r;
    assign upd_valid = upd_valid_r;
    assign upd_tid   = upd_tid_r;
    assign pending   = pending_r;
    assign rd_avg    = avg_r[rd_tid];
    assign rd_inst   = inst_r[rd_tid];

endmodule

// File: tb/tb_tm_stats_sched.sv
// Testbench for tm_stats_sched: a 4-stage ALU model, a per-thread running
// average reference, a scoreboard of expected writebacks, and a monitor that
// pops and checks on every upd_valid.
module tb_tm_stats_sched;
    localparam int N   = 4;
    localparam int TW  = 2;
    localparam int LAT = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_curlen = '0;
    logic [N-1:0]   req_ready;
    logic           clr_valid = 1'b0;
    logic [TW-1:0]  clr_tid = '0;
    logic [7:0]     alu_avg, alu_inst, alu_cur;
    logic [7:0]     alu_avg_new, alu_inst_new;
    logic           upd_valid;
    logic [TW-1:0]  upd_tid;
    logic [N-1:0]   pending;
    logic [TW-1:0]  rd_tid;
    logic [7:0]     rd_avg, rd_inst;

    logic [TW-1:0]  drv_rd = '0;
    logic [TW-1:0]  mon_rd = '0;
    logic           mon_sel = 1'b0;
    assign rd_tid = mon_sel ? mon_rd : drv_rd;

    tm_stats_sched #(.NUM_THREADS(N), .TID_W(TW), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_curlen(req_curlen),
        .req_ready(req_ready), .clr_valid(clr_valid), .clr_tid(clr_tid),
        .alu_avg(alu_avg), .alu_inst(alu_inst), .alu_cur(alu_cur),
        .alu_avg_new(alu_avg_new), .alu_inst_new(alu_inst_new),
        .upd_valid(upd_valid), .upd_tid(upd_tid), .pending(pending),
        .rd_tid(rd_tid), .rd_avg(rd_avg), .rd_inst(rd_inst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: samples operands each edge, result emerges LAT edges later.
    logic [7:0] pa [LAT];
    logic [7:0] pi [LAT];
    always @(posedge clk) begin
        pa[0] <= 8'((int'(alu_avg) * int'(alu_inst) + int'(alu_cur)) / (int'(alu_inst) + 1));
        pi[0] <= alu_inst + 8'd1;
        for (int k = 1; k < LAT; k++) begin
            pa[k] <= pa[k-1];
            pi[k] <= pi[k-1];
        end
    end
    assign alu_avg_new  = pa[LAT-1];
    assign alu_inst_new = pi[LAT-1];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    typedef struct {
        int tid;
        int avg;
        int inst;
        int due;
    } exp_t;
    exp_t sbq[$];

    // Reference state: stored stats, in-flight flags, round-robin pointer.
    int m_avg [N];
    int m_inst[N];
    bit m_pend[N];
    int m_ptr = 0;

    logic           s_reset = 1'b1;
    logic [N-1:0]   s_valid = '0;
    logic [8*N-1:0] s_cur = '0;
    logic           s_clr = 1'b0;
    logic [TW-1:0]  s_clr_tid = '0;
    logic [TW-1:0]  s_rd = '0;
    bit             s_rdchk = 1'b0;
    bit             alu_chk = 1'b0;
    bit             rst_chk = 1'b0;
    int             x_avg = 0, x_inst = 0, x_cur = 0;
    int             last_g = -1;

    // One clock: drive at negedge, check, then advance the model over the next edge.
    task automatic cycle();
        int g, i, up, cur, ai, pv;
        exp_t e;
        @(negedge clk);
        reset      = s_reset;
        req_valid  = s_valid;
        req_curlen = s_cur;
        clr_valid  = s_clr;
        clr_tid    = s_clr_tid;
        drv_rd     = s_rd;
        #1;
        if (alu_chk) begin
            chk("alu_avg", alu_avg, x_avg);
            chk("alu_inst", alu_inst, x_inst);
            chk("alu_cur", alu_cur, x_cur);
            alu_chk = 1'b0;
        end
        if (rst_chk) begin
            chk("rst_upd_valid", upd_valid, 0);
            chk("rst_upd_tid", upd_tid, 0);
            rst_chk = 1'b0;
        end
        up = cyc + 1;
        g  = -1;
        if (!s_reset) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (g < 0 && s_valid[i] && !m_pend[i] && !(s_clr && int'(s_clr_tid) == i)) g = i;
            end
        end
        chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
        pv = 0;
        for (int k = 0; k < N; k++) if (m_pend[k]) pv |= (1 << k);
        chk("pending", pending, pv);
        if (s_rdchk) begin
            chk("rd_avg", rd_avg, m_avg[s_rd]);
            chk("rd_inst", rd_inst, m_inst[s_rd]);
        end
        last_g = g;
        if (s_reset) begin
            sbq.delete();
            for (int k = 0; k < N; k++) begin
                m_avg[k] = 0; m_inst[k] = 0; m_pend[k] = 1'b0;
            end
            m_ptr = 0;
            x_avg = 0; x_inst = 0; x_cur = 0;
            alu_chk = 1'b1;
            rst_chk = 1'b1;
        end else begin
            if (s_clr) begin
                for (int q = sbq.size() - 1; q >= 0; q--)
                    if (sbq[q].tid == int'(s_clr_tid)) sbq.delete(q);
                m_avg[s_clr_tid]  = 0;
                m_inst[s_clr_tid] = 0;
                m_pend[s_clr_tid] = 1'b0;
            end
            foreach (sbq[q]) begin
                if (sbq[q].due == up) begin
                    m_avg[sbq[q].tid]  = sbq[q].avg;
                    m_inst[sbq[q].tid] = sbq[q].inst;
                    m_pend[sbq[q].tid] = 1'b0;
                end
            end
            if (g >= 0) begin
                cur    = int'(s_cur[8*g +: 8]);
                ai     = (m_inst[g] == 255) ? 254 : m_inst[g];
                e.tid  = g;
                e.avg  = (m_avg[g] * ai + cur) / (ai + 1);
                e.inst = (m_inst[g] == 255) ? 255 : ai + 1;
                e.due  = up + LAT + 1;
                sbq.push_back(e);
                m_pend[g] = 1'b1;
                m_ptr     = (g + 1) % N;
                x_avg = m_avg[g]; x_inst = ai; x_cur = cur;
                alu_chk = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        s_valid = '0;
        s_clr   = 1'b0;
        repeat (n) cycle();
    endtask

    // Request one update for tid, hold until granted, then wait for its writeback.
    task automatic req_once(input int tid, input int cur);
        int n;
        s_cur[8*tid +: 8] = cur[7:0];
        s_valid[tid] = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (last_g != tid && n < 40);
        s_valid[tid] = 1'b0;
        n = 0;
        while (m_pend[tid] && n < 40) begin
            cycle();
            n++;
        end
    endtask

    task automatic rd_expect(input int tid, input int a, input int ins);
        s_rd    = tid[TW-1:0];
        s_rdchk = 1'b1;
        cycle();
        chk("rd_avg_directed", rd_avg, a);
        chk("rd_inst_directed", rd_inst, ins);
        s_rdchk = 1'b0;
    endtask

    // Scoreboard monitor: every upd_valid must match the oldest expected writeback.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (upd_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_unexpected: got upd_tid=%0d, expected no writeback (cycle %0d)", upd_tid, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("upd_time", cyc, e.due);
                    chk("upd_tid", upd_tid, e.tid);
                    mon_rd  = upd_tid;
                    mon_sel = 1'b1;
                    #1;
                    chk("wb_avg", rd_avg, e.avg);
                    chk("wb_inst", rd_inst, e.inst);
                    mon_sel = 1'b0;
                end
            end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
                chk("upd_missing", upd_valid, 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin : stim
        int prev;
        int n;
        // Reset
        s_reset = 1'b1;
        cycle();
        cycle();
        s_reset = 1'b0;
        rd_expect(0, 0, 0);

        // Running average on T0: 10, 20, 3
        req_once(0, 10);
        rd_expect(0, 10, 1);
        req_once(0, 20);
        rd_expect(0, 15, 2);
        req_once(0, 3);
        rd_expect(0, 11, 3);

        // T0 held continuously: grants exactly LAT+2 apart
        s_cur[7:0] = 8'd7;
        s_valid    = 4'b0001;
        prev = -1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (req_ready[0]) begin
                if (prev >= 0) chk("t0_spacing", c - prev, LAT + 2);
                prev = c;
            end
        end
        idle(8);

        // All threads request from pointer 0: T0,T1,T2,T3 back to back
        s_reset = 1'b1;
        cycle();
        s_reset = 1'b0;
        s_cur   = 32'h28_1E_14_0A;
        s_valid = 4'hF;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("rr_order", req_ready, 1 << c);
        end
        repeat (12) cycle();
        idle(8);

        // T1 saturation
        s_clr = 1'b1; s_clr_tid = 2'd1;
        cycle();
        s_clr = 1'b0;
        for (int u = 0; u < 255; u++) req_once(1, 100);
        rd_expect(1, 100, 255);
        req_once(1, 200);
        chk("sat_alu_inst", alu_inst, 254);
        rd_expect(1, 100, 255);

        // T2 cleared two cycles after its grant, then re-granted at once
        idle(2);
        s_cur[23:16] = 8'd50;
        s_valid[2]   = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (last_g != 2 && n < 20);
        s_valid[2] = 1'b0;
        cycle();
        s_clr = 1'b1; s_clr_tid = 2'd2;
        cycle();
        s_clr = 1'b0;
        s_cur[23:16] = 8'd60;
        s_valid[2]   = 1'b1;
        s_rd         = 2'd2;
        cycle();
        chk("t2_regrant", req_ready, 4'b0100);
        chk("t2_clr_avg", rd_avg, 0);
        chk("t2_clr_inst", rd_inst, 0);
        s_valid[2] = 1'b0;
        idle(LAT + 2);
        rd_expect(2, 60, 1);

        // Reset with three ops in flight
        s_valid = 4'b0111;
        repeat (3) cycle();
        s_valid = '0;
        cycle();
        s_reset = 1'b1;
        cycle();
        s_reset = 1'b0;
        idle(10);
        for (int t = 0; t < N; t++) rd_expect(t, 0, 0);

        // Randomized traffic with clears and readback
        s_rdchk = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_valid[i] && ($urandom % 3 == 0)) begin
                    s_valid[i]     = 1'b1;
                    s_cur[8*i +: 8] = 8'($urandom);
                end
            end
            s_clr     = ($urandom % 16 == 0);
            s_clr_tid = TW'($urandom);
            s_rd      = TW'($urandom);
            cycle();
            if (last_g >= 0) s_valid[last_g] = 1'b0;
        end
        s_rdchk = 1'b0;
        idle(12);
        chk("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
